// File: rtl/eel_run_sequencer.sv
`default_nettype none
// ============================================================================
// eel_run_sequencer: staggered core-reset release, run-cycle counting and
// halt/timeout run termination for NUM_CH EEL core instances.
// Revision: 1.0
// ============================================================================
module eel_run_sequencer #(
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned HOLD_CYCLES    = 4,
    parameter int unsigned STAGGER_CYCLES = 2,
    parameter int unsigned MAX_CYCLES     = 30,
    parameter int unsigned CNT_W          = 16,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [NUM_CH-1:0] HALT_REQ,
    output logic [NUM_CH-1:0] CORE_RST,
    output logic              RUNNING,
    output logic              DONE,
    output logic              TIMEOUT,
    output logic [NUM_CH-1:0] HALT_SRC,
    output logic [CNT_W-1:0]  CYCLE_CNT
);

    localparam int unsigned TMR_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int          TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int          CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] STAG_LAST = TMR_W'((STAGGER_CYCLES > 0) ? (STAGGER_CYCLES - 1) : 0);
    localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(NUM_CH - 1);
    localparam bit               DIRECT_RUN = (NUM_CH == 1) || (STAGGER_CYCLES == 0);

    generate
        if (NUM_CH < 1 || HOLD_CYCLES < 1) begin : g_shape_err
            $error("eel_run_sequencer: NUM_CH and HOLD_CYCLES must be >= 1");
        end
        if (CNT_W < 32) begin : g_budget_check
            if (64'(MAX_CYCLES) >= (64'd1 << CNT_W)) begin : g_budget_err
                $error("eel_run_sequencer: MAX_CYCLES does not fit in CNT_W bits");
            end
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    state_t             state_q,    state_d;
    logic [NUM_CH-1:0]  core_rst_q, core_rst_d;
    logic               done_q,     done_d;
    logic               timeout_q,  timeout_d;
    logic [NUM_CH-1:0]  halt_src_q, halt_src_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [TMR_W-1:0]   tmr_q,      tmr_d;
    logic [CH_W-1:0]    ch_idx_q,   ch_idx_d;

    logic               w_halt_hit;
    logic               w_budget_hit;
    logic [32:0]        w_cnt_inc;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            core_rst_q <= '1;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            halt_src_q <= '0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            ch_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            halt_src_q <= halt_src_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            ch_idx_q   <= ch_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        timeout_d  = timeout_q;
        halt_src_d = halt_src_q;
        cnt_d      = cnt_q;
        tmr_d      = tmr_q;
        ch_idx_d   = ch_idx_q;

        // Budget compare is done one bit wider than 32 so the +1 cannot wrap.
        w_halt_hit   = |HALT_REQ;
        w_cnt_inc    = 33'(cnt_q) + 33'd1;
        w_budget_hit = (MAX_CYCLES != 0) && (w_cnt_inc == 33'(MAX_CYCLES));

        case (state_q)
            ST_IDLE: begin
                core_rst_d = '1;
                if (AUTO_START || START) begin
                    state_d = ST_HOLD;
                    tmr_d   = '0;
                end
            end
            ST_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    tmr_d    = '0;
                    ch_idx_d = CH_W'(1);
                    if (DIRECT_RUN) begin
                        core_rst_d = '0;
                        cnt_d      = '0;
                        state_d    = ST_RUN;
                    end else begin
                        core_rst_d[0] = 1'b0;
                        state_d       = ST_RELEASE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_RELEASE: begin
                if (tmr_q == STAG_LAST) begin
                    tmr_d                = '0;
                    core_rst_d[ch_idx_q] = 1'b0;
                    ch_idx_d             = ch_idx_q + CH_W'(1);
                    if (ch_idx_q == LAST_CH) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_RUN: begin
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                if (w_halt_hit || w_budget_hit) begin
                    state_d    = ST_HALT;
                    halt_src_d = HALT_REQ;
                    timeout_d  = w_budget_hit;
                    done_d     = 1'b1;
                    core_rst_d = '1;
                end
            end
            ST_HALT: begin
                if (START) begin
                    state_d    = ST_HOLD;
                    tmr_d      = '0;
                    done_d     = 1'b0;
                    timeout_d  = 1'b0;
                    halt_src_d = '0;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign CORE_RST  = core_rst_q;
    assign RUNNING   = (state_q == ST_RUN);
    assign DONE      = done_q;
    assign TIMEOUT   = timeout_q;
    assign HALT_SRC  = halt_src_q;
    assign CYCLE_CNT = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eel_run_sequencer.sv
`default_nettype none
// ============================================================================
// tb_eel_run_sequencer: directed bench for default and 4-channel/no-stagger configs.
// Revision: 1.0
// ============================================================================
module tb_eel_run_sequencer;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        START4;
    logic [1:0]  HALT_REQ;
    logic [3:0]  HALT_REQ4;

    logic [1:0]  CORE_RST;
    logic        RUNNING;
    logic        DONE;
    logic        TIMEOUT;
    logic [1:0]  HALT_SRC;
    logic [15:0] CYCLE_CNT;

    logic [3:0]  CORE_RST4;
    logic        RUNNING4;
    logic        DONE4;
    logic        TIMEOUT4;
    logic [3:0]  HALT_SRC4;
    logic [15:0] CYCLE_CNT4;

    int n_checks = 0;
    int n_errors = 0;

    eel_run_sequencer dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .HALT_REQ  (HALT_REQ),
        .CORE_RST  (CORE_RST),
        .RUNNING   (RUNNING),
        .DONE      (DONE),
        .TIMEOUT   (TIMEOUT),
        .HALT_SRC  (HALT_SRC),
        .CYCLE_CNT (CYCLE_CNT)
    );

    eel_run_sequencer #(
        .NUM_CH         (4),
        .STAGGER_CYCLES (0),
        .AUTO_START     (1'b0)
    ) dut4 (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START4),
        .HALT_REQ  (HALT_REQ4),
        .CORE_RST  (CORE_RST4),
        .RUNNING   (RUNNING4),
        .DONE      (DONE4),
        .TIMEOUT   (TIMEOUT4),
        .HALT_SRC  (HALT_SRC4),
        .CYCLE_CNT (CYCLE_CNT4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        RST       = 1'b0;
        START     = 1'b0;
        START4    = 1'b0;
        HALT_REQ  = 2'b00;
        HALT_REQ4 = 4'b0000;

        #12;
        check("rst_core_rst", CORE_RST, 2'b11);
        check("rst_running",  RUNNING,  1'b0);
        check("rst_done",     DONE,     1'b0);
        check("rst_timeout",  TIMEOUT,  1'b0);
        check("rst_halt_src", HALT_SRC, 2'b00);
        check("rst_cnt",      CYCLE_CNT, 16'd0);
        check("rst_core_rst4", CORE_RST4, 4'hF);

        @(posedge CLK); #1;
        RST = 1'b1;

        // Startup: bit0 drops at edge 5, bit1 and RUN at edge 7
        tick(4);
        check("t1_e4_core_rst", CORE_RST, 2'b11);
        tick(1);
        check("t1_e5_core_rst", CORE_RST, 2'b10);
        check("t1_e5_running",  RUNNING,  1'b0);
        tick(1);
        check("t1_e6_core_rst", CORE_RST, 2'b10);
        tick(1);
        check("t1_e7_core_rst", CORE_RST, 2'b00);
        check("t1_e7_running",  RUNNING,  1'b1);
        check("t1_e7_cnt",      CYCLE_CNT, 16'd0);

        // Budget expiry at edge 37
        tick(29);
        check("t2_e36_cnt",  CYCLE_CNT, 16'd29);
        check("t2_e36_done", DONE, 1'b0);
        tick(1);
        check("t2_done",     DONE, 1'b1);
        check("t2_timeout",  TIMEOUT, 1'b1);
        check("t2_cnt",      CYCLE_CNT, 16'd30);
        check("t2_core_rst", CORE_RST, 2'b11);
        check("t2_running",  RUNNING, 1'b0);
        check("t2_halt_src", HALT_SRC, 2'b00);

        // HALT_REQ outside RUN is ignored; HALT state is frozen
        HALT_REQ = 2'b11;
        tick(3);
        HALT_REQ = 2'b00;
        check("halt_frozen_src", HALT_SRC, 2'b00);
        check("halt_frozen_cnt", CYCLE_CNT, 16'd30);
        check("halt_frozen_done", DONE, 1'b1);

        // START in HALT clears status and restarts the sequence
        START = 1'b1;
        tick(1);
        START = 1'b0;
        check("t6_clr_done",    DONE, 1'b0);
        check("t6_clr_timeout", TIMEOUT, 1'b0);
        check("t6_clr_cnt",     CYCLE_CNT, 16'd0);
        check("t6_clr_core",    CORE_RST, 2'b11);
        tick(3);
        check("t6_hold_core",   CORE_RST, 2'b11);
        tick(1);
        check("t6_rel0_core",   CORE_RST, 2'b10);
        tick(2);
        check("t6_run_core",    CORE_RST, 2'b00);
        check("t6_run_running", RUNNING, 1'b1);

        // START in RUN is ignored, then a halt request at count 10
        tick(5);
        check("t6_run_cnt5", CYCLE_CNT, 16'd5);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        check("t6_start_ign_cnt", CYCLE_CNT, 16'd6);
        check("t6_start_ign_run", RUNNING, 1'b1);
        check("t6_start_ign_core", CORE_RST, 2'b00);
        tick(4);
        check("t3_cnt10", CYCLE_CNT, 16'd10);
        HALT_REQ = 2'b10;
        tick(1);
        HALT_REQ = 2'b00;
        check("t3_halt_src", HALT_SRC, 2'b10);
        check("t3_cnt",      CYCLE_CNT, 16'd11);
        check("t3_timeout",  TIMEOUT, 1'b0);
        check("t3_done",     DONE, 1'b1);
        check("t3_running",  RUNNING, 1'b0);
        check("t3_core_rst", CORE_RST, 2'b11);

        // Halt request coinciding with timeout
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(6);
        check("t4_run", RUNNING, 1'b1);
        tick(29);
        check("t4_cnt29", CYCLE_CNT, 16'd29);
        HALT_REQ = 2'b01;
        tick(1);
        HALT_REQ = 2'b00;
        check("t4_timeout",  TIMEOUT, 1'b1);
        check("t4_halt_src", HALT_SRC, 2'b01);
        check("t4_cnt",      CYCLE_CNT, 16'd30);
        check("t4_done",     DONE, 1'b1);

        // Asynchronous reset mid-run
        START = 1'b1;
        tick(1);
        START = 1'b0;
        tick(6);
        tick(5);
        check("t5_cnt5", CYCLE_CNT, 16'd5);
        #2;
        RST = 1'b0;
        #1;
        check("t5_core_rst", CORE_RST, 2'b11);
        check("t5_running",  RUNNING, 1'b0);
        check("t5_cnt",      CYCLE_CNT, 16'd0);
        check("t5_done",     DONE, 1'b0);
        check("t5_halt_src", HALT_SRC, 2'b00);
        @(posedge CLK); #1;
        RST = 1'b1;
        tick(4);
        check("t5_e4_core_rst", CORE_RST, 2'b11);
        tick(1);
        check("t5_e5_core_rst", CORE_RST, 2'b10);
        tick(2);
        check("t5_e7_core_rst", CORE_RST, 2'b00);
        check("t5_e7_running",  RUNNING, 1'b1);

        // Four channels, no stagger: all bits drop together
        check("t6b_idle_core", CORE_RST4, 4'hF);
        check("t6b_idle_run",  RUNNING4, 1'b0);
        START4 = 1'b1;
        tick(1);
        START4 = 1'b0;
        check("t6b_hold_core", CORE_RST4, 4'hF);
        tick(3);
        check("t6b_hold3_core", CORE_RST4, 4'hF);
        tick(1);
        check("t6b_rel_core", CORE_RST4, 4'h0);
        check("t6b_rel_run",  RUNNING4, 1'b1);
        check("t6b_rel_cnt",  CYCLE_CNT4, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
